// File: rtl/k_and_s_pkg.sv
// ============================================================================
// Module      : k_and_s_pkg
// Description : Shared types for the K-and-S processor control path.
//               Holds the decoded opcode enum, the ALU operation codes, the
//               control FSM state enum, and the opcode-to-ALU-op helper.
//               Optional feature macro: KS_SINGLE_STEP_EN adds the STEP_WAIT
//               state, and every path back to FETCH goes through it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package k_and_s_pkg;

    // Opcode as decoded from the instruction register. The 5-bit width
    // leaves encodings unused; the control unit treats those as NOP.
    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_HALT   = 5'd15
    } decoded_instruction_type;

    // ALU operation select codes
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    typedef enum logic [3:0] {
        FETCH       = 4'd0,
        DECODE      = 4'd1,
        LOAD_1      = 4'd2,
        LOAD_2      = 4'd3,
        STORE_1     = 4'd4,
        ALU_EXEC    = 4'd5,
        MOVE_EXEC   = 4'd6,
        BRANCH_EXEC = 4'd7,
        HALTED      = 4'd8
`ifdef KS_SINGLE_STEP_EN
        ,
        STEP_WAIT   = 4'd9
`endif
    } state_t;

    // Every completed instruction returns here
`ifdef KS_SINGLE_STEP_EN
    localparam state_t ST_RETURN = STEP_WAIT;
`else
    localparam state_t ST_RETURN = FETCH;
`endif

    // ALU operation for the arithmetic/logic opcodes (ADD for anything else)
    function automatic logic [1:0] alu_op_of(input decoded_instruction_type instr);
        logic [1:0] op;
        case (instr)
            I_SUB:   op = OP_SUB;
            I_AND:   op = OP_AND;
            I_OR:    op = OP_OR;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module      : control_unit
// Description : Moore control FSM for the K-and-S processor. It sequences
//               fetch, decode and one of the execute paths
//               (load/store/ALU/move/branch/halt). All datapath controls
//               are decoded from registered state only.
//               Optional feature macro: KS_SINGLE_STEP_EN adds the step
//               input and the STEP_WAIT state.
// Ports       : clk, rst (async, active high)
//               decoded_instruction            - opcode from the datapath IR
//               zero_op/neg_op/*_overflow      - registered datapath flags
//               branch, pc_enable, ir_enable, addr_sel, c_sel,
//               write_reg_enable, flags_reg_enable, operation[1:0],
//               ram_write_enable                - datapath controls
//               halt                            - processor stopped
//               step (KS_SINGLE_STEP_EN only)   - single-step advance
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
`ifdef KS_SINGLE_STEP_EN
    input  logic                    step,
`endif
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic [1:0]              operation,
    output logic                    ram_write_enable,
    output logic                    halt
);

    state_t     state_q, state_d;
    // ALU op latched in DECODE, so ALU_EXEC outputs come from registers only
    logic [1:0] alu_op_q, alu_op_d;

    // No branch condition uses the unsigned overflow flag
    logic unused_flags;
    assign unused_flags = unsigned_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH;
            alu_op_q <= OP_ADD;
        end else begin
            state_q  <= state_d;
            alu_op_q <= alu_op_d;
        end
    end

    // Next-state logic; branch flags are sampled while in DECODE
    always_comb begin
        state_d  = state_q;
        alu_op_d = alu_op_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                alu_op_d = alu_op_of(decoded_instruction);
                case (decoded_instruction)
                    I_LOAD:   state_d = LOAD_1;
                    I_STORE:  state_d = STORE_1;
                    I_ADD, I_SUB, I_AND, I_OR:
                              state_d = ALU_EXEC;
                    I_MOVE:   state_d = MOVE_EXEC;
                    I_BRANCH: state_d = BRANCH_EXEC;
                    I_BZERO:  state_d = zero_op          ? BRANCH_EXEC : ST_RETURN;
                    I_BNZERO: state_d = !zero_op         ? BRANCH_EXEC : ST_RETURN;
                    I_BNEG:   state_d = neg_op           ? BRANCH_EXEC : ST_RETURN;
                    I_BNNEG:  state_d = !neg_op          ? BRANCH_EXEC : ST_RETURN;
                    I_BOV:    state_d = signed_overflow  ? BRANCH_EXEC : ST_RETURN;
                    I_BNOV:   state_d = !signed_overflow ? BRANCH_EXEC : ST_RETURN;
                    I_HALT:   state_d = HALTED;
                    default:  state_d = ST_RETURN;  // NOP and undefined opcodes
                endcase
            end
            LOAD_1:      state_d = LOAD_2;
            LOAD_2,
            STORE_1,
            ALU_EXEC,
            MOVE_EXEC,
            BRANCH_EXEC: state_d = ST_RETURN;
            HALTED:      state_d = HALTED;
`ifdef KS_SINGLE_STEP_EN
            STEP_WAIT:   state_d = step ? FETCH : STEP_WAIT;
`endif
            default:     state_d = FETCH;
        endcase
    end

    // Moore output decode. While rst is held every control is forced low
    // so no strobe can fire while an aborted instruction is being flushed.
    always_comb begin
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        operation        = OP_ADD;
        ram_write_enable = 1'b0;
        halt             = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH:       ir_enable = 1'b1;
                DECODE:      pc_enable = 1'b1;
                LOAD_1:      addr_sel  = 1'b1;
                LOAD_2: begin
                    addr_sel         = 1'b1;
                    c_sel            = 1'b1;
                    write_reg_enable = 1'b1;
                end
                STORE_1: begin
                    addr_sel         = 1'b1;
                    ram_write_enable = 1'b1;
                end
                ALU_EXEC: begin
                    operation        = alu_op_q;
                    write_reg_enable = 1'b1;
                    flags_reg_enable = 1'b1;
                end
                MOVE_EXEC: begin
                    operation        = OP_OR;
                    write_reg_enable = 1'b1;
                end
                BRANCH_EXEC: begin
                    branch    = 1'b1;
                    pc_enable = 1'b1;
                end
                HALTED:      halt = 1'b1;
                default:     ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module      : tb_control_unit
// Description : Self-checking bench for control_unit. A table of opcode and
//               flag records, each with its expected execute-phase output
//               words, is replayed through a scoreboard queue. Hand-written
//               sequences cover reset mid-LOAD, HALT hold, and (with
//               KS_SINGLE_STEP_EN) the STEP_WAIT dwell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;
    import k_and_s_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic step;
    decoded_instruction_type decoded_instruction;
    logic zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic branch, pc_enable, ir_enable, addr_sel, c_sel;
    logic write_reg_enable, flags_reg_enable, ram_write_enable, halt;
    logic [1:0] operation;

    always #5 clk = ~clk;

    control_unit dut (
        .clk                 (clk),
        .rst                 (rst),
`ifdef KS_SINGLE_STEP_EN
        .step                (step),
`endif
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .write_reg_enable    (write_reg_enable),
        .flags_reg_enable    (flags_reg_enable),
        .operation           (operation),
        .ram_write_enable    (ram_write_enable),
        .halt                (halt)
    );

    // Output word: {branch,pc,ir,addr,csel,wr,flags,op[1:0],ramwr,halt}
    logic [10:0] dut_vec;
    assign dut_vec = {branch, pc_enable, ir_enable, addr_sel, c_sel,
                      write_reg_enable, flags_reg_enable, operation,
                      ram_write_enable, halt};

    function automatic logic [10:0] mk(input logic br, pc, ir, as, cs, wr, fl,
                                       input logic [1:0] op,
                                       input logic rw, h);
        return {br, pc, ir, as, cs, wr, fl, op, rw, h};
    endfunction

    logic [10:0] v_fetch, v_decode, v_zero, v_halt;

    typedef struct {
        string                   name;
        decoded_instruction_type op;
        logic                    z, n, sv, uv;
        int                      n_exec;
        logic [10:0]             e0, e1;
    } vec_t;

    vec_t        tbl[$];
    logic [10:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // Compare the current outputs against the oldest expected word
    task automatic compare_now(input string name);
        logic [10:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %b", name, dut_vec);
        end else begin
            e = exp_q.pop_front();
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b", name, dut_vec, e);
            end
        end
    endtask

    // One clock: sample at negedge, then move to just after the next posedge
    task automatic step_cycle(input string name);
        @(negedge clk);
        compare_now(name);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int total;
        decoded_instruction = v.op;
        zero_op            = v.z;
        neg_op             = v.n;
        signed_overflow    = v.sv;
        unsigned_overflow  = v.uv;
        exp_q.push_back(v_fetch);
        exp_q.push_back(v_decode);
        if (v.n_exec >= 1) exp_q.push_back(v.e0);
        if (v.n_exec >= 2) exp_q.push_back(v.e1);
        total = 2 + v.n_exec;
`ifdef KS_SINGLE_STEP_EN
        exp_q.push_back(v_zero);
        exp_q.push_back(v_zero);
        total += 2;
`endif
        for (int i = 0; i < total; i++) begin
`ifdef KS_SINGLE_STEP_EN
            step = (i == total - 1);
`endif
            step_cycle(v.name);
        end
        step = 1'b0;
    endtask

    function automatic vec_t mkv(input string name, input decoded_instruction_type op,
                                 input logic z, n, sv, uv, input int ne,
                                 input logic [10:0] e0, e1);
        vec_t v;
        v.name = name; v.op = op; v.z = z; v.n = n; v.sv = sv; v.uv = uv;
        v.n_exec = ne; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    initial begin
        logic [10:0] v_br, v_ld1, v_ld2, v_st;
        v_fetch  = mk(0,0,1,0,0,0,0,OP_ADD,0,0);
        v_decode = mk(0,1,0,0,0,0,0,OP_ADD,0,0);
        v_zero   = '0;
        v_halt   = mk(0,0,0,0,0,0,0,OP_ADD,0,1);
        v_br     = mk(1,1,0,0,0,0,0,OP_ADD,0,0);
        v_ld1    = mk(0,0,0,1,0,0,0,OP_ADD,0,0);
        v_ld2    = mk(0,0,0,1,1,1,0,OP_ADD,0,0);
        v_st     = mk(0,0,0,1,0,0,0,OP_ADD,1,0);

        tbl.push_back(mkv("load",      I_LOAD,   0,0,0,0, 2, v_ld1, v_ld2));
        tbl.push_back(mkv("store",     I_STORE,  0,0,0,0, 1, v_st, '0));
        tbl.push_back(mkv("add",       I_ADD,    0,0,0,0, 1, mk(0,0,0,0,0,1,1,OP_ADD,0,0), '0));
        tbl.push_back(mkv("sub",       I_SUB,    1,1,1,1, 1, mk(0,0,0,0,0,1,1,OP_SUB,0,0), '0));
        tbl.push_back(mkv("and",       I_AND,    0,0,0,0, 1, mk(0,0,0,0,0,1,1,OP_AND,0,0), '0));
        tbl.push_back(mkv("or",        I_OR,     0,0,0,0, 1, mk(0,0,0,0,0,1,1,OP_OR,0,0), '0));
        tbl.push_back(mkv("move",      I_MOVE,   0,0,0,0, 1, mk(0,0,0,0,0,1,0,OP_OR,0,0), '0));
        tbl.push_back(mkv("branch",    I_BRANCH, 0,0,0,0, 1, v_br, '0));
        tbl.push_back(mkv("bzero_t",   I_BZERO,  1,0,0,0, 1, v_br, '0));
        tbl.push_back(mkv("bzero_nt",  I_BZERO,  0,1,1,1, 0, '0, '0));
        tbl.push_back(mkv("bnzero_t",  I_BNZERO, 0,0,0,0, 1, v_br, '0));
        tbl.push_back(mkv("bnzero_nt", I_BNZERO, 1,0,0,0, 0, '0, '0));
        tbl.push_back(mkv("bneg_t",    I_BNEG,   0,1,0,0, 1, v_br, '0));
        tbl.push_back(mkv("bneg_nt",   I_BNEG,   1,0,1,1, 0, '0, '0));
        tbl.push_back(mkv("bnneg_t",   I_BNNEG,  0,0,0,0, 1, v_br, '0));
        tbl.push_back(mkv("bnneg_nt",  I_BNNEG,  0,1,0,0, 0, '0, '0));
        tbl.push_back(mkv("bov_t",     I_BOV,    0,0,1,0, 1, v_br, '0));
        tbl.push_back(mkv("bov_nt",    I_BOV,    1,1,0,1, 0, '0, '0));
        tbl.push_back(mkv("bnov_t",    I_BNOV,   0,0,0,1, 1, v_br, '0));
        tbl.push_back(mkv("bnov_nt",   I_BNOV,   0,0,1,0, 0, '0, '0));
        tbl.push_back(mkv("nop",       I_NOP,    1,1,1,1, 0, '0, '0));
        tbl.push_back(mkv("undef",     decoded_instruction_type'(5'd25), 1,1,1,1, 0, '0, '0));

        // Reset state: all controls low while rst is held
        rst = 1'b1; step = 1'b0;
        decoded_instruction = I_NOP;
        zero_op = 0; neg_op = 0; signed_overflow = 0; unsigned_overflow = 0;
        #2;
        exp_q.push_back(v_zero);
        compare_now("reset_hold");
        exp_q.push_back(v_zero);
        step_cycle("reset_hold_clk");
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset in the middle of LOAD_1: strobes stay low, restart at FETCH
        decoded_instruction = I_LOAD;
        exp_q.push_back(v_fetch);
        exp_q.push_back(v_decode);
        exp_q.push_back(v_ld1);
        step_cycle("rst_load_fetch");
        step_cycle("rst_load_decode");
        @(negedge clk);
        compare_now("rst_load_ld1");
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back(v_zero);
        compare_now("rst_mid_load");
        @(posedge clk); #1;
        exp_q.push_back(v_zero);
        compare_now("rst_mid_load_clk");
        rst = 1'b0;
        #1;
        exp_q.push_back(v_fetch);
        compare_now("rst_release_fetch");
        run_vec(tbl[2]);

        // HALT holds for 20 cycles, step ignored, released only by reset
        decoded_instruction = I_HALT;
        exp_q.push_back(v_fetch);
        exp_q.push_back(v_decode);
        step_cycle("halt_fetch");
        step_cycle("halt_decode");
        for (int i = 0; i < 20; i++) begin
            step = i[0];
            exp_q.push_back(v_halt);
            step_cycle("halt_hold");
        end
        step = 1'b0;
        rst = 1'b1;
        #1;
        exp_q.push_back(v_zero);
        compare_now("halt_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        run_vec(tbl[6]);

`ifdef KS_SINGLE_STEP_EN
        // STORE then a 10-cycle STEP_WAIT dwell before a step pulse
        decoded_instruction = I_STORE;
        exp_q.push_back(v_fetch);
        exp_q.push_back(v_decode);
        exp_q.push_back(v_st);
        step_cycle("ss_fetch");
        step_cycle("ss_decode");
        step_cycle("ss_store");
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(v_zero);
            step_cycle("ss_wait");
        end
        step = 1'b1;
        exp_q.push_back(v_zero);
        step_cycle("ss_step");
        step = 1'b0;
        exp_q.push_back(v_fetch);
        step_cycle("ss_back_fetch");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous active-high reset.
REQ-003 SHALL have ports: decoded_instruction  in  decoded_instruction_type  current IR opcode from datapath.
REQ-004 SHALL have ports: zero_op, neg_op, unsigned_overflow, signed_overflow  in  1 each  registered datapath flags.
REQ-005 SHALL have ports: branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable, flags_reg_enable  out  1 each  datapath controls.
REQ-006 SHALL have ports: operation  out  2  ALU op select.
REQ-007 SHALL have ports: ram_write_enable  out  1  RAM write strobe.
REQ-008 SHALL have ports: halt  out  1  processor stopped.
REQ-009 SHALL have ports: step  in  1  single-step advance, present only under KS_SINGLE_STEP_EN.

Function
REQ-010 SHALL be a Moore FSM; outputs decoded from state only, one instruction step per state per cycle.
REQ-011 SHALL use states: FETCH, DECODE, LOAD_1, LOAD_2, STORE_1, ALU_EXEC, MOVE_EXEC, BRANCH_EXEC, HALTED, and STEP_WAIT under the macro.
REQ-012 SHALL drive all outputs 0 in every state unless listed below.
REQ-013 SHALL in FETCH assert ir_enable=1, addr_sel=0; always next DECODE.
REQ-014 SHALL in DECODE assert pc_enable=1 (PC+1), then branch on decoded_instruction.
REQ-015 SHALL route LOAD: LOAD_1 (addr_sel=1) -> LOAD_2 (addr_sel=1, c_sel=1, write_reg_enable=1) -> FETCH; 3 cycles after DECODE.
REQ-016 SHALL route STORE: STORE_1 (addr_sel=1, ram_write_enable=1) -> FETCH.
REQ-017 SHALL route ADD/SUB/AND/OR: ALU_EXEC (operation=package code, c_sel=0, write_reg_enable=1, flags_reg_enable=1) -> FETCH.
REQ-018 SHALL route MOVE: MOVE_EXEC (operation=OP_OR, write_reg_enable=1, flags_reg_enable=0) -> FETCH.
REQ-019 SHALL evaluate BRANCH unconditional; BZERO/BNZERO on zero_op=1/0; BNEG/BNNEG on neg_op=1/0; BOV/BNOV on signed_overflow=1/0; flags sampled in DECODE.
REQ-020 SHALL on taken branch go BRANCH_EXEC (branch=1, pc_enable=1) -> FETCH; not taken goes directly FETCH.
REQ-021 SHALL treat NOP and any undefined opcode as not-taken: DECODE -> FETCH.
REQ-022 SHALL on HALT enter HALTED, assert halt=1, hold all other outputs 0, and remain until reset.
REQ-023 SHALL never assert write_reg_enable and ram_write_enable in the same cycle.

Reset
REQ-024 SHALL on rst=1 immediately force state FETCH-pending (reset state = FETCH) and all outputs 0 except those of FETCH after release.
REQ-025 SHALL abort any in-flight instruction on reset mid-operation; no write strobe asserted during or after reset until a new DECODE.
REQ-026 SHALL restart at FETCH on the first rising clk after rst deasserts.

Configuration
REQ-027 SHALL with KS_SINGLE_STEP_EN defined: every path returning to FETCH go to STEP_WAIT instead; STEP_WAIT holds all outputs 0 and exits to FETCH on a cycle with step=1; step ignored in other states.
REQ-028 SHALL without KS_SINGLE_STEP_EN: no step port, no STEP_WAIT state, behaviour per REQ-013..022.

Structure
REQ-029 SHALL take decoded_instruction_type, ALU op codes (OP_ADD, OP_SUB, OP_AND, OP_OR) and the FSM state enum from k_and_s_pkg.
REQ-030 SHALL be a single module, no sub-modules; state register plus combinational next-state/output logic.

Verification
REQ-031 SHALL cover reset: rst=1 mid LOAD_1 -> ram_write_enable/write_reg_enable 0, after release first cycle ir_enable=1, addr_sel=0.
REQ-032 SHALL cover LOAD: opcode LOAD -> cycle sequence ir_enable, pc_enable, addr_sel=1, then c_sel=1+write_reg_enable=1, then FETCH; 4 cycles total.
REQ-033 SHALL cover ADD then SUB: operation=OP_ADD then OP_SUB in ALU_EXEC with flags_reg_enable=1; MOVE shows flags_reg_enable=0.
REQ-034 SHALL cover BZERO with zero_op=1 -> branch=1,pc_enable=1 one cycle; with zero_op=0 -> no branch, next state FETCH; same for BNEG/BOV pairs.
REQ-035 SHALL cover HALT: halt=1 held 20 cycles, no other output toggles; rst releases to FETCH.
REQ-036 SHALL cover KS_SINGLE_STEP_EN: after STORE sits in STEP_WAIT 10 cycles with step=0, step=1 pulse -> FETCH next cycle.
